// File: rtl/note_map_pkg.sv
// ============================================================================
// Module   : note_map_pkg
// Brief    : Shared command/state encodings and default sizing for the note map.
// Revision : 1.0
// ============================================================================
`default_nettype none

package note_map_pkg;

    localparam int DEFAULT_SIZE       = 128;
    localparam int DEFAULT_CLR_STRIDE = 8;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_SET     = 2'b01,
        OP_CLR     = 2'b10,
        OP_CLR_ALL = 2'b11
    } op_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/chunk_popcount.sv
// ============================================================================
// Module   : chunk_popcount
// Brief    : Combinational population count of one WIDTH-bit clear chunk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module chunk_popcount #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]             bits_i,
    output logic [$clog2(WIDTH+1)-1:0]   pop_o
);

    localparam int POP_W = $clog2(WIDTH + 1);

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_o = pop_o + POP_W'(bits_i[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/note_map_decoder.sv
// ============================================================================
// Module   : note_map_decoder
// Brief    : Note-slot bitmap with SET/CLR/CLR_ALL commands; CLR_ALL sweeps the
//            map CLR_STRIDE bits per cycle. NOTE_MAP_DECODER_COUNT_EN adds a
//            live count of set bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module note_map_decoder
    import note_map_pkg::*;
#(
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int CLR_STRIDE = DEFAULT_CLR_STRIDE
) (
    input  logic                     clk50M,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [$clog2(SIZE)-1:0]  in_index,
    output logic [SIZE-1:0]          map,
    output logic [SIZE-1:0]          onehot,
    output logic                     busy
`ifdef NOTE_MAP_DECODER_COUNT_EN
    ,
    output logic [$clog2(SIZE):0]    count
`endif
);

    localparam int NCHUNK = SIZE / CLR_STRIDE;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NCHUNK - 1);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [SIZE-1:0]   map_q, map_d;
    logic [SIZE-1:0]   onehot_q, onehot_d;
    logic              cmd_accept;
    op_e               op;

    assign op         = op_e'(in_op);
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == SWEEP);
    assign cmd_accept = in_valid && in_ready;
    assign map        = map_q;
    assign onehot     = onehot_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        map_d    = map_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    case (op)
                        OP_SET: begin
                            map_d[in_index] = 1'b1;
                            onehot_d        = SIZE'(1) << in_index;
                        end
                        OP_CLR: begin
                            map_d[in_index] = 1'b0;
                            onehot_d        = SIZE'(1) << in_index;
                        end
                        OP_CLR_ALL: begin
                            onehot_d = '0;
                            ptr_d    = '0;
                            state_d  = SWEEP;
                        end
                        default: ;
                    endcase
                end
            end
            SWEEP: begin
                // Constant part-selects keep the chunk clear a plain decoded mux.
                for (int c = 0; c < NCHUNK; c++) begin
                    if (ptr_q == PTR_W'(c)) begin
                        map_d[c*CLR_STRIDE +: CLR_STRIDE] = '0;
                    end
                end
                ptr_d = ptr_q + PTR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    ptr_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            map_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            map_q    <= map_d;
            onehot_q <= onehot_d;
        end
    end

`ifdef NOTE_MAP_DECODER_COUNT_EN
    localparam int CNT_W = $clog2(SIZE) + 1;
    localparam int POP_W = $clog2(CLR_STRIDE + 1);

    logic [CLR_STRIDE-1:0] sweep_chunk;
    logic [POP_W-1:0]      chunk_pop;
    logic [CNT_W-1:0]      count_q, count_d;

    always_comb begin
        sweep_chunk = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (ptr_q == PTR_W'(c)) begin
                sweep_chunk = map_q[c*CLR_STRIDE +: CLR_STRIDE];
            end
        end
    end

    chunk_popcount #(
        .WIDTH (CLR_STRIDE)
    ) u_chunk_popcount (
        .bits_i (sweep_chunk),
        .pop_o  (chunk_pop)
    );

    // Only real transitions move the count, so it stays within 0..SIZE.
    always_comb begin
        count_d = count_q;
        if (state_q == SWEEP) begin
            count_d = count_q - CNT_W'(chunk_pop);
        end else if (cmd_accept && (op == OP_SET) && !map_q[in_index]) begin
            count_d = count_q + CNT_W'(1);
        end else if (cmd_accept && (op == OP_CLR) && map_q[in_index]) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

endmodule

`default_nettype wire
